// File: rtl/div_share_ctrl_pkg.sv
// Shared types and constants for the divider-sharing controller.
package div_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ERR_OK  = 2'b00,
    ERR_DBZ = 2'b01,
    ERR_TMO = 2'b10
  } err_t;

  localparam int DEFAULT_TIMEOUT = 40;

  // Wide enough for any supported operand width; users slice [WIDTH-1:0].
  localparam int                   MAX_WIDTH = 64;
  localparam logic [MAX_WIDTH-1:0] DBZ_QUOT  = '1;

endpackage

// File: rtl/div_share_ctrl_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping at NREQ.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  input  logic            enable,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx
);

  localparam int SW = IW + 1;

  logic [IW-1:0] cand [NREQ];
  logic          found;

  // cand[gi] is the requester examined at priority position gi.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
    logic [SW-1:0] sum;
    assign sum       = {1'b0, ptr} + SW'(gi);
    assign cand[gi]  = (sum >= SW'(NREQ)) ? IW'(sum - SW'(NREQ)) : sum[IW-1:0];
  end

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (enable && !found && req[cand[i]]) begin
        gnt[cand[i]] = 1'b1;
        idx          = cand[i];
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/div_share_ctrl.sv
// Shares one iterative start/done divider among NREQ requesters with round-robin
// arbitration, local divide-by-zero handling and a RUN watchdog.
module div_share_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_dividend,
  input  logic [NREQ*WIDTH-1:0] req_divisor,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]      rsp_quot,
  output logic [WIDTH-1:0]      rsp_rem,
  output logic [1:0]            rsp_err,
  output logic                  div_start,
  output logic [WIDTH-1:0]      div_dividend,
  output logic [WIDTH-1:0]      div_divisor,
  input  logic                  div_done,
  input  logic [WIDTH-1:0]      div_quot,
  input  logic [WIDTH-1:0]      div_rem,
  output logic                  busy
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  state_t           state_reg, state_next;
  logic [IW-1:0]    ptr_reg, ptr_next;
  logic [IW-1:0]    idx_reg, idx_next;
  logic [WIDTH-1:0] dividend_reg, dividend_next;
  logic [WIDTH-1:0] divisor_reg, divisor_next;
  logic [WIDTH-1:0] quot_reg, quot_next;
  logic [WIDTH-1:0] rem_reg, rem_next;
  err_t             err_reg, err_next;
  logic [CW-1:0]    cnt_reg, cnt_next;

  logic [NREQ-1:0]  gnt;
  logic [IW-1:0]    gnt_idx;
  logic [WIDTH-1:0] dvd_arr [NREQ];
  logic [WIDTH-1:0] dvs_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
    assign dvd_arr[gi]   = req_dividend[gi*WIDTH +: WIDTH];
    assign dvs_arr[gi]   = req_divisor[gi*WIDTH +: WIDTH];
    assign rsp_valid[gi] = (state_reg == RESP) && (idx_reg == IW'(gi));
  end

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req    (req_valid),
    .ptr    (ptr_reg),
    .enable (state_reg == IDLE),
    .gnt    (gnt),
    .idx    (gnt_idx)
  );

  assign req_ready    = gnt;
  assign div_start    = (state_reg == RUN);
  assign div_dividend = dividend_reg;
  assign div_divisor  = divisor_reg;
  assign rsp_quot     = quot_reg;
  assign rsp_rem      = rem_reg;
  assign rsp_err      = err_reg;
  assign busy         = (state_reg != IDLE);

  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    idx_next      = idx_reg;
    dividend_next = dividend_reg;
    divisor_next  = divisor_reg;
    quot_next     = quot_reg;
    rem_next      = rem_reg;
    err_next      = err_reg;
    cnt_next      = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (|gnt) begin
          idx_next      = gnt_idx;
          ptr_next      = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
          dividend_next = dvd_arr[gnt_idx];
          divisor_next  = dvs_arr[gnt_idx];
          cnt_next      = '0;
          // A zero divisor is answered locally; the divider never sees it.
          if (dvs_arr[gnt_idx] == '0) begin
            quot_next  = DBZ_QUOT[WIDTH-1:0];
            rem_next   = dvd_arr[gnt_idx];
            err_next   = ERR_DBZ;
            state_next = RESP;
          end else begin
            state_next = RUN;
          end
        end
      end
      RUN: begin
        // done is tested first so it wins over a coincident timeout.
        if (div_done) begin
          quot_next  = div_quot;
          rem_next   = div_rem;
          err_next   = ERR_OK;
          cnt_next   = '0;
          state_next = RESP;
        end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
          quot_next  = '0;
          rem_next   = '0;
          err_next   = ERR_TMO;
          cnt_next   = '0;
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready[idx_reg]) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      ptr_reg      <= '0;
      idx_reg      <= '0;
      dividend_reg <= '0;
      divisor_reg  <= '0;
      quot_reg     <= '0;
      rem_reg      <= '0;
      err_reg      <= ERR_OK;
      cnt_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      idx_reg      <= idx_next;
      dividend_reg <= dividend_next;
      divisor_reg  <= divisor_next;
      quot_reg     <= quot_next;
      rem_reg      <= rem_next;
      err_reg      <= err_next;
      cnt_reg      <= cnt_next;
    end
  end

endmodule

// File: tb/tb_div_share_ctrl.sv
// Self-checking bench for div_share_ctrl with a behavioural 33-cycle divider.
module tb_div_share_ctrl;

  localparam int NREQ    = 4;
  localparam int WIDTH   = 32;
  localparam int TIMEOUT = 40;
  localparam int DIV_LAT = 33;

  typedef struct {
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic [1:0]       e;
  } res_t;

  typedef struct {
    int               id;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic [1:0]       e;
  } vec_t;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b1;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_dividend;
  logic [NREQ*WIDTH-1:0] req_divisor;
  logic [NREQ-1:0]       rsp_valid;
  logic [NREQ-1:0]       rsp_ready = '0;
  logic [WIDTH-1:0]      rsp_quot, rsp_rem;
  logic [1:0]            rsp_err;
  logic                  div_start;
  logic [WIDTH-1:0]      div_dividend, div_divisor;
  logic                  div_done = 1'b0;
  logic [WIDTH-1:0]      div_quot = '0, div_rem = '0;
  logic                  busy;

  logic [WIDTH-1:0] op_a [NREQ];
  logic [WIDTH-1:0] op_b [NREQ];
  bit               div_en = 1'b1;
  int               ptr_m = 0;
  int               n_vec = 0;
  int               n_err = 0;
  int               dcnt = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      req_dividend[k*WIDTH +: WIDTH] = op_a[k];
      req_divisor[k*WIDTH +: WIDTH]  = op_b[k];
    end
  end

  div_share_ctrl #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_quot(rsp_quot), .rsp_rem(rsp_rem), .rsp_err(rsp_err),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_done(div_done), .div_quot(div_quot), .div_rem(div_rem),
    .busy(busy)
  );

  // Behavioural divider: result and done appear DIV_LAT cycles after start is first sampled.
  always @(posedge clk) begin
    if (!div_start) begin
      dcnt     <= 0;
      div_done <= 1'b0;
    end else begin
      dcnt <= dcnt + 1;
      if (dcnt == DIV_LAT - 1 && div_en) begin
        div_done <= 1'b1;
        div_quot <= (div_divisor != 0) ? div_dividend / div_divisor : '1;
        div_rem  <= (div_divisor != 0) ? div_dividend % div_divisor : div_dividend;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] m, input int p);
    for (int o = 0; o < NREQ; o++)
      if (m[(p + o) % NREQ]) return (p + o) % NREQ;
    return 0;
  endfunction

  function automatic res_t ref_div(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit en);
    res_t r;
    if (b == 0)   begin r.q = '1;    r.r = a;     r.e = 2'b01; end
    else if (!en) begin r.q = '0;    r.r = '0;    r.e = 2'b10; end
    else          begin r.q = a / b; r.r = a % b; r.e = 2'b00; end
    return r;
  endfunction

  // Starts and ends at 1 time unit after a falling edge.
  task automatic do_op(input logic [NREQ-1:0] mask, input int bp, input bit keep,
                       output int g_idx, output int g_wait,
                       output logic [WIDTH-1:0] g_a, output logic [WIDTH-1:0] g_b,
                       output logic [WIDTH-1:0] g_q, output logic [WIDTH-1:0] g_r,
                       output logic [1:0] g_e);
    int exp_idx, exp_lat, lat, starts, cyc, bad;
    logic [NREQ-1:0] gbit;
    g_idx = -1; g_wait = -1; g_a = '0; g_b = '0; g_q = '0; g_r = '0; g_e = '0;
    exp_idx = rr_pick(mask, ptr_m);
    gbit = NREQ'(1 << exp_idx);
    req_valid = mask;
    #1;
    cyc = 0;
    while (req_ready == '0 && cyc < 60) begin
      @(negedge clk); #1; cyc++;
    end
    g_wait = cyc;
    check("grant", req_ready, gbit);
    if (req_ready != gbit) begin
      req_valid = '0;
      return;
    end
    g_idx = exp_idx;
    ptr_m = (exp_idx + 1) % NREQ;
    g_a = op_a[exp_idx];
    g_b = op_b[exp_idx];
    exp_lat = (g_b == 0) ? 1 : (!div_en ? TIMEOUT + 1 : DIV_LAT + 2);
    @(negedge clk);
    req_valid = keep ? (mask & ~gbit) : '0;
    op_a[exp_idx] = $urandom;
    op_b[exp_idx] = $urandom;
    #1;
    lat = 1; starts = 0; bad = 0;
    while (rsp_valid == '0 && lat < 120) begin
      if (div_start) begin
        starts++;
        if (div_dividend !== g_a || div_divisor !== g_b) bad++;
      end
      if (req_ready != '0 || !busy) bad++;
      @(negedge clk); #1; lat++;
    end
    check("rsp_latency", lat, exp_lat);
    check("div_start_cycles", starts, exp_lat - 1);
    check("run_protocol", bad, 0);
    check("rsp_valid_onehot", rsp_valid, gbit);
    g_q = rsp_quot; g_r = rsp_rem; g_e = rsp_err;
    bad = 0;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk); #1;
      if (rsp_valid !== gbit || rsp_quot !== g_q || rsp_rem !== g_r || rsp_err !== g_e ||
          req_ready != '0 || div_start) bad++;
    end
    if (bp > 0) check("backpressure_hold", bad, 0);
    rsp_ready = gbit;
    @(negedge clk); #1;
    check("rsp_complete", rsp_valid, '0);
    check("idle_after_rsp", busy, 1'b0);
    rsp_ready = '0;
    $display("req %0d: 0x%08h / 0x%08h -> quot 0x%08h rem 0x%08h err %0d (lat %0d)",
             g_idx, g_a, g_b, g_q, g_r, g_e, lat);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ptr_m = 0;
    #1;
  endtask

  initial begin
    vec_t tbl[8];
    int order[5];
    int gi, gw, cyc;
    logic [WIDTH-1:0] ga, gb, gq, gr;
    logic [1:0] ge;
    res_t exp_r;
    logic [NREQ-1:0] m;

    for (int k = 0; k < NREQ; k++) begin op_a[k] = '0; op_b[k] = 32'd1; end
    tbl[0] = '{0, 32'd100,        32'd7,  32'd14,        32'd2,   2'b00};
    tbl[1] = '{2, 32'd5,          32'd0,  32'hFFFF_FFFF, 32'd5,   2'b01};
    tbl[2] = '{1, 32'd9,          32'd3,  32'd3,         32'd0,   2'b00};
    tbl[3] = '{3, 32'hFFFF_FFFF,  32'h10, 32'h0FFF_FFFF, 32'hF,   2'b00};
    tbl[4] = '{0, 32'd0,          32'd5,  32'd0,         32'd0,   2'b00};
    tbl[5] = '{1, 32'd7,          32'd9,  32'd0,         32'd7,   2'b00};
    tbl[6] = '{3, 32'd0,          32'd0,  32'hFFFF_FFFF, 32'd0,   2'b01};
    tbl[7] = '{2, 32'h8000_0000,  32'd1,  32'h8000_0000, 32'd0,   2'b00};
    order = '{0, 1, 2, 3, 0};

    // Reset state
    #2 rst_n = 1'b0;
    @(negedge clk); #1;
    check("reset_req_ready", req_ready, '0);
    check("reset_rsp_valid", rsp_valid, '0);
    check("reset_rsp_data", {rsp_quot, rsp_rem}, '0);
    check("reset_rsp_err", rsp_err, 2'b00);
    check("reset_div_start", div_start, 1'b0);
    check("reset_div_ops", {div_dividend, div_divisor}, '0);
    check("reset_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    ptr_m = 0;
    #1;

    // Directed table
    for (int i = 0; i < 8; i++) begin
      op_a[tbl[i].id] = tbl[i].a;
      op_b[tbl[i].id] = tbl[i].b;
      do_op(NREQ'(1 << tbl[i].id), 0, 1'b0, gi, gw, ga, gb, gq, gr, ge);
      check("tbl_quot", gq, tbl[i].q);
      check("tbl_rem", gr, tbl[i].r);
      check("tbl_err", ge, tbl[i].e);
    end

    // Round-robin fairness from pointer 0, all requesters held valid
    do_reset();
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < NREQ; k++) begin op_a[k] = 32'(1000 + k); op_b[k] = 32'd10; end
      do_op('1, 0, 1'b1, gi, gw, ga, gb, gq, gr, ge);
      check("rr_order", gi, order[i]);
      check("rr_quot", gq, 32'd100);
      check("rr_rem", gr, 32'(order[i]));
      if (i > 0) check("rr_back_to_back", gw, 0);
    end
    req_valid = '0;

    // Backpressure on requester 1 with requester 0 waiting
    op_a[1] = 32'd50; op_b[1] = 32'd6;
    op_a[0] = 32'd77; op_b[0] = 32'd8;
    do_op(4'b0011, 20, 1'b1, gi, gw, ga, gb, gq, gr, ge);
    check("bp_idx", gi, 1);
    check("bp_quot", gq, 32'd8);
    check("bp_rem", gr, 32'd2);
    op_a[0] = 32'd77; op_b[0] = 32'd8;
    do_op(4'b0001, 0, 1'b0, gi, gw, ga, gb, gq, gr, ge);
    check("bp_next_grant_wait", gw, 0);
    check("bp_next_quot", {gq, gr}, {32'd9, 32'd5});

    // Timeout, then recovery with a working divider
    div_en = 1'b0;
    op_a[2] = 32'd123; op_b[2] = 32'd4;
    do_op(4'b0100, 0, 1'b0, gi, gw, ga, gb, gq, gr, ge);
    check("tmo_result", {gq, gr}, '0);
    check("tmo_err", ge, 2'b10);
    div_en = 1'b1;
    op_a[2] = 32'd9; op_b[2] = 32'd3;
    do_op(4'b0100, 0, 1'b0, gi, gw, ga, gb, gq, gr, ge);
    check("post_tmo_result", {gq, gr, 30'd0, ge}, {32'd3, 32'd0, 32'd0});

    // Reset 10 cycles into RUN
    op_a[1] = 32'd500; op_b[1] = 32'd3;
    req_valid = 4'b0010;
    #1;
    cyc = 0;
    while (req_ready == '0 && cyc < 60) begin @(negedge clk); #1; cyc++; end
    check("rst_grant", req_ready, 4'b0010);
    @(negedge clk);
    req_valid = '0;
    repeat (10) @(negedge clk);
    #1;
    check("rst_pre_start", div_start, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_div_start", div_start, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_rsp_valid", rsp_valid, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ptr_m = 0;
    #1;
    check("rst_no_replay", rsp_valid, '0);
    op_a[3] = 32'hFFFF_FFFF; op_b[3] = 32'h10;
    do_op(4'b1000, 0, 1'b0, gi, gw, ga, gb, gq, gr, ge);
    check("post_rst_result", {gq, gr}, {32'h0FFF_FFFF, 32'hF});

    // Randomised traffic against the reference model
    for (int i = 0; i < 25; i++) begin
      m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int k = 0; k < NREQ; k++) begin
        op_a[k] = $urandom;
        case ($urandom_range(0, 9))
          0, 1:       op_b[k] = '0;
          2, 3, 4, 5: op_b[k] = $urandom_range(1, 20);
          default:    op_b[k] = $urandom;
        endcase
      end
      div_en = ($urandom_range(0, 9) != 0);
      do_op(m, $urandom_range(0, 3), 1'b0, gi, gw, ga, gb, gq, gr, ge);
      exp_r = ref_div(ga, gb, div_en);
      check("rand_quot", gq, exp_r.q);
      check("rand_rem", gr, exp_r.r);
      check("rand_err", ge, exp_r.e);
    end
    div_en = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
